spike_synapse: RTL and testbench
================================

SPIKE_SYNAPSE -- requirements
Module: spike_synapse

Interface
REQ-001 Parameter DECAY_PERIOD, default 4: cycles between decay steps; legal range 1..256.
REQ-002 Parameter DECAY_SHIFT, default 2: right-shift amount for the decay step; legal range 1..7.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  synchronous, active-high reset (reset asserted when rst_n=1), sampled on rising clk.
REQ-005 spike_in  input  4  presynaptic spike events, one bit per synapse, each high cycle = one event.
REQ-006 wr_en  input  1  weight write strobe.
REQ-007 wr_addr  input  2  weight index to write.
REQ-008 wr_data  input  8  unsigned weight value.
REQ-009 sat_clr  input  1  clears sticky saturation flag.
REQ-010 synaptic_current  output  8  unsigned current, drives the LIF neuron's synaptic_current input.
REQ-011 active  output  1  high when synaptic_current != 0.
REQ-012 sat_flag  output  1  sticky flag: a clamp at 255 or 0 has occurred.

Function
REQ-013 Four 8-bit weight registers SHALL be held; wr_en=1 loads wr_data into weight[wr_addr] at the clock edge.
REQ-014 A weight written in cycle n SHALL first affect accumulation in cycle n+1; a spike on the same index in cycle n uses the old weight.
REQ-015 An 8-bit decay counter SHALL count 0..DECAY_PERIOD-1 every cycle and wrap; decay_tick is high when count == DECAY_PERIOD-1.
REQ-016 With DECAY_PERIOD=1, decay_tick SHALL be high every cycle.
REQ-017 On decay_tick: d = current >> DECAY_SHIFT; if current != 0 and d == 0, then d = 1; decayed = current - d. Otherwise decayed = current.
REQ-018 Excitatory sum SHALL be computed in 10 bits as the sum of weight[i] for each asserted excitatory spike_in[i].
REQ-019 next = decayed + excitatory sum; if next > 255, current SHALL clamp to 255 and sat_flag SHALL set.
REQ-020 Decay SHALL be applied before the spike contribution within the same cycle.
REQ-021 Latency: a spike sampled at edge n SHALL be visible on synaptic_current immediately after edge n (one register stage, no combinational input-to-output path).
REQ-022 active SHALL be registered alongside synaptic_current, consistent with it in every cycle.
REQ-023 sat_flag SHALL stay set until sat_clr; if a clamp and sat_clr occur in the same cycle, sat_flag SHALL remain 1 (set wins).
REQ-024 With all spike_in low, current SHALL decay monotonically to exactly 0 and hold at 0.

Reset
REQ-025 rst_n=1 at an edge SHALL clear synaptic_current, active, sat_flag, all four weights and the decay counter to 0; it overrides wr_en, spike_in and sat_clr in the same cycle.
REQ-026 Reset asserted mid-decay or mid-accumulation SHALL discard all in-flight state; after release, the counter restarts at 0.

Configuration
REQ-027 Macro SYN_INHIBIT_EN defined: spike_in[3] is inhibitory; weight[3] is subtracted after the excitatory add (and after any clamp to 255), floored at 0; a floor clamp sets sat_flag.
REQ-028 Macro SYN_INHIBIT_EN undefined: all four inputs are excitatory; no subtract path is built.

Verification
REQ-029 Reset, then spike_in=4'b1111 with weights at 0 -> synaptic_current=0, active=0, sat_flag=0.
REQ-030 DECAY_PERIOD=4, DECAY_SHIFT=2; weight[0]=40; spike_in=4'b0001 for 1 cycle at counter=0 -> current=40; at the next decay_tick -> 30, then 23.
REQ-031 Weights 0..2 = 200, spike_in=4'b0111 -> current=255, sat_flag=1; sat_clr=1 -> sat_flag=0; sat_clr coincident with a new clamp -> sat_flag=1.
REQ-032 Current=3, no spikes -> 2, 1, 0 on successive ticks; active falls with the 0; current stays 0.
REQ-033 Current=50, weight[3]=80, spike_in=4'b1000 -> 0 with sat_flag=1 (SYN_INHIBIT_EN) / 130 (without).
REQ-034 Current=100, rst_n=1 for one cycle mid-decay -> current=0, weights=0, counter=0; a subsequent spike adds 0.

Source files
------------

// File: rtl/spike_synapse.sv
// spike_synapse: four-input weighted synapse with periodic multiplicative decay.
// Spike events add their weight to an 8-bit current that saturates at 255 and
// decays by current>>DECAY_SHIFT (at least 1) every DECAY_PERIOD cycles.
// Optional build macro SYN_INHIBIT_EN: spike_in[3] becomes inhibitory and
// subtracts weight[3] after the excitatory add, flooring at 0.
// rst_n is an active-high synchronous reset despite its name.
module spike_synapse #(
   parameter int DECAY_PERIOD = 4,
   parameter int DECAY_SHIFT  = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] spike_in,
   input  logic       wr_en,
   input  logic [1:0] wr_addr,
   input  logic [7:0] wr_data,
   input  logic       sat_clr,
   output logic [7:0] synaptic_current,
   output logic       active,
   output logic       sat_flag
);

   // Synapses that contribute positively to the sum.
`ifdef SYN_INHIBIT_EN
   localparam logic [3:0] EXC_MASK = 4'b0111;
`else
   localparam logic [3:0] EXC_MASK = 4'b1111;
`endif

   localparam logic [7:0] TICK_AT = 8'(DECAY_PERIOD - 1);

   logic [7:0] weight_q [4];
   logic [7:0] weight_d [4];
   logic [7:0] cnt_q, cnt_d;
   logic [7:0] cur_q, cur_d;
   logic       active_q, active_d;
   logic       sat_q, sat_d;

   logic       decay_tick;
   logic [7:0] decay_step;
   logic [7:0] decayed;
   logic [9:0] exc_term [4];
   logic [9:0] exc_sum;
   logic [10:0] next_sum;
   logic [7:0] clamped;
   logic       clamp_hi;
   logic       clamp_lo;

   // Gate each weight by its spike; inhibitory inputs contribute nothing here.
   for (genvar gi = 0; gi < 4; gi++) begin : g_term
      assign exc_term[gi] = (spike_in[gi] && EXC_MASK[gi]) ? {2'b00, weight_q[gi]} : 10'd0;
   end

   assign exc_sum    = exc_term[0] + exc_term[1] + exc_term[2] + exc_term[3];
   assign decay_tick = (cnt_q == TICK_AT);

   // Weight file update: writes land at the edge, so a same-cycle spike sees the old value.
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         weight_d[i] = weight_q[i];
         if (wr_en && (wr_addr == 2'(i))) begin
            weight_d[i] = wr_data;
         end
      end
   end

   // Decay counter wraps at DECAY_PERIOD-1; period 1 makes every cycle a tick.
   always_comb begin
      cnt_d = decay_tick ? 8'd0 : cnt_q + 8'd1;
   end

   // Decay first, then add spikes, clamp high, then optional inhibitory subtract.
   always_comb begin
      decay_step = 8'd0;
      decayed    = cur_q;
      if (decay_tick) begin
         decay_step = cur_q >> DECAY_SHIFT;
         // Guarantee small currents still drain to exactly zero.
         if (cur_q != 8'd0 && decay_step == 8'd0) begin
            decay_step = 8'd1;
         end
         decayed = cur_q - decay_step;
      end

      next_sum = {3'b000, decayed} + {1'b0, exc_sum};
      clamp_hi = (next_sum > 11'd255);
      clamped  = clamp_hi ? 8'd255 : next_sum[7:0];
      clamp_lo = 1'b0;
      cur_d    = clamped;
`ifdef SYN_INHIBIT_EN
      if (spike_in[3]) begin
         if (weight_q[3] > clamped) begin
            clamp_lo = 1'b1;
            cur_d    = 8'd0;
         end else begin
            cur_d = clamped - weight_q[3];
         end
      end
`endif
      active_d = (cur_d != 8'd0);
      // A new clamp wins over a coincident clear.
      sat_d    = clamp_hi | clamp_lo | (sat_q & ~sat_clr);
   end

   // State registers with synchronous reset overriding all other inputs.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         for (int i = 0; i < 4; i++) begin
            weight_q[i] <= 8'd0;
         end
         cnt_q    <= 8'd0;
         cur_q    <= 8'd0;
         active_q <= 1'b0;
         sat_q    <= 1'b0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            weight_q[i] <= weight_d[i];
         end
         cnt_q    <= cnt_d;
         cur_q    <= cur_d;
         active_q <= active_d;
         sat_q    <= sat_d;
      end
   end

   assign synaptic_current = cur_q;
   assign active           = active_q;
   assign sat_flag         = sat_q;

endmodule

// File: tb/tb_spike_synapse.sv
// Directed self-checking bench for spike_synapse with default parameters
// (DECAY_PERIOD=4, DECAY_SHIFT=2). Expected values are hand-computed per cycle.
module tb_spike_synapse;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] spike_in;
   logic       wr_en;
   logic [1:0] wr_addr;
   logic [7:0] wr_data;
   logic       sat_clr;
   logic [7:0] synaptic_current;
   logic       active;
   logic       sat_flag;

   int n_checks = 0;
   int n_fail   = 0;

   spike_synapse #(.DECAY_PERIOD(4), .DECAY_SHIFT(2)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .spike_in         (spike_in),
      .wr_en            (wr_en),
      .wr_addr          (wr_addr),
      .wr_data          (wr_data),
      .sat_clr          (sat_clr),
      .synaptic_current (synaptic_current),
      .active           (active),
      .sat_flag         (sat_flag)
   );

   always #5 clk = ~clk;

   // Advance one edge; outputs are then sampled 1 time unit after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      spike_in = 4'b0000;
      wr_en    = 1'b0;
      wr_addr  = 2'd0;
      wr_data  = 8'd0;
      sat_clr  = 1'b0;
   endtask

   task automatic write_w(input logic [1:0] a, input logic [7:0] d);
      idle();
      wr_en   = 1'b1;
      wr_addr = a;
      wr_data = d;
      step();
      idle();
   endtask

   // After this the next edge sees decay counter = 0.
   task automatic do_reset();
      idle();
      rst_n = 1'b1;
      step();
      rst_n = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++; if (synaptic_current !== 8'd0) begin n_fail++; $display("FAIL reset_cur: got %0d expected 0", synaptic_current); end
      n_checks++; if (active !== 1'b0) begin n_fail++; $display("FAIL reset_active: got %b expected 0", active); end
      n_checks++; if (sat_flag !== 1'b0) begin n_fail++; $display("FAIL reset_sat: got %b expected 0", sat_flag); end
      spike_in = 4'b1111;
      step();
      idle();
      n_checks++; if (synaptic_current !== 8'd0) begin n_fail++; $display("FAIL zero_w_cur: got %0d expected 0", synaptic_current); end
      n_checks++; if (active !== 1'b0) begin n_fail++; $display("FAIL zero_w_active: got %b expected 0", active); end
      n_checks++; if (sat_flag !== 1'b0) begin n_fail++; $display("FAIL zero_w_sat: got %b expected 0", sat_flag); end
      $display("test_reset done: cur=%0d active=%b sat=%b", synaptic_current, active, sat_flag);
   endtask

   task automatic test_decay();
      do_reset();
      write_w(2'd0, 8'd40);          // cnt0
      step(); step(); step();        // cnt1..cnt3 (tick on zero current)
      spike_in = 4'b0001;            // cnt0
      step();
      idle();
      n_checks++; if (synaptic_current !== 8'd40) begin n_fail++; $display("FAIL decay_load: got %0d expected 40", synaptic_current); end
      n_checks++; if (active !== 1'b1) begin n_fail++; $display("FAIL decay_active: got %b expected 1", active); end
      step(); step();                // cnt1, cnt2
      n_checks++; if (synaptic_current !== 8'd40) begin n_fail++; $display("FAIL decay_hold: got %0d expected 40", synaptic_current); end
      step();                        // cnt3 tick: 40 - 10
      n_checks++; if (synaptic_current !== 8'd30) begin n_fail++; $display("FAIL decay_tick1: got %0d expected 30", synaptic_current); end
      step(); step(); step(); step(); // tick: 30 - 7
      n_checks++; if (synaptic_current !== 8'd23) begin n_fail++; $display("FAIL decay_tick2: got %0d expected 23", synaptic_current); end
      $display("test_decay done: cur=%0d", synaptic_current);
   endtask

   task automatic test_write_latency();
      do_reset();
      wr_en = 1'b1; wr_addr = 2'd0; wr_data = 8'd10; spike_in = 4'b0001; // cnt0: old weight 0
      step();
      idle();
      n_checks++; if (synaptic_current !== 8'd0) begin n_fail++; $display("FAIL wr_same_cycle: got %0d expected 0", synaptic_current); end
      spike_in = 4'b0001;            // cnt1: weight now 10
      step();
      n_checks++; if (synaptic_current !== 8'd10) begin n_fail++; $display("FAIL wr_next_cycle: got %0d expected 10", synaptic_current); end
      wr_en = 1'b1; wr_addr = 2'd0; wr_data = 8'd20; spike_in = 4'b0001; // cnt2: 10+10
      step();
      n_checks++; if (synaptic_current !== 8'd20) begin n_fail++; $display("FAIL wr_old_weight: got %0d expected 20", synaptic_current); end
      wr_en = 1'b0; spike_in = 4'b0001; // cnt3 tick: (20-5)+20
      step();
      idle();
      n_checks++; if (synaptic_current !== 8'd35) begin n_fail++; $display("FAIL decay_then_add: got %0d expected 35", synaptic_current); end
      $display("test_write_latency done: cur=%0d", synaptic_current);
   endtask

   task automatic test_saturation();
      do_reset();
      write_w(2'd0, 8'd200);         // cnt0
      write_w(2'd1, 8'd200);         // cnt1
      write_w(2'd2, 8'd200);         // cnt2
      spike_in = 4'b0111;            // cnt3: 0 + 600
      step();
      idle();
      n_checks++; if (synaptic_current !== 8'd255) begin n_fail++; $display("FAIL sat_cur: got %0d expected 255", synaptic_current); end
      n_checks++; if (sat_flag !== 1'b1) begin n_fail++; $display("FAIL sat_set: got %b expected 1", sat_flag); end
      sat_clr = 1'b1;                // cnt0: no clamp
      step();
      idle();
      n_checks++; if (sat_flag !== 1'b0) begin n_fail++; $display("FAIL sat_clear: got %b expected 0", sat_flag); end
      n_checks++; if (synaptic_current !== 8'd255) begin n_fail++; $display("FAIL sat_hold_cur: got %0d expected 255", synaptic_current); end
      sat_clr = 1'b1; spike_in = 4'b0001; // cnt1: clamp and clear together
      step();
      idle();
      n_checks++; if (sat_flag !== 1'b1) begin n_fail++; $display("FAIL sat_set_wins: got %b expected 1", sat_flag); end
      step();                        // cnt2: sticky
      n_checks++; if (sat_flag !== 1'b1) begin n_fail++; $display("FAIL sat_sticky: got %b expected 1", sat_flag); end
      $display("test_saturation done: cur=%0d sat=%b", synaptic_current, sat_flag);
   endtask

   task automatic test_decay_to_zero();
      do_reset();
      write_w(2'd0, 8'd3);           // cnt0
      spike_in = 4'b0001;            // cnt1
      step();
      idle();
      step();                        // cnt2
      n_checks++; if (synaptic_current !== 8'd3) begin n_fail++; $display("FAIL dz_load: got %0d expected 3", synaptic_current); end
      step();                        // cnt3 tick: min step 1
      n_checks++; if (synaptic_current !== 8'd2) begin n_fail++; $display("FAIL dz_2: got %0d expected 2", synaptic_current); end
      step(); step(); step(); step();
      n_checks++; if (synaptic_current !== 8'd1) begin n_fail++; $display("FAIL dz_1: got %0d expected 1", synaptic_current); end
      n_checks++; if (active !== 1'b1) begin n_fail++; $display("FAIL dz_active1: got %b expected 1", active); end
      step(); step(); step(); step();
      n_checks++; if (synaptic_current !== 8'd0) begin n_fail++; $display("FAIL dz_0: got %0d expected 0", synaptic_current); end
      n_checks++; if (active !== 1'b0) begin n_fail++; $display("FAIL dz_active0: got %b expected 0", active); end
      step(); step(); step(); step();
      n_checks++; if (synaptic_current !== 8'd0) begin n_fail++; $display("FAIL dz_hold: got %0d expected 0", synaptic_current); end
      $display("test_decay_to_zero done: cur=%0d active=%b", synaptic_current, active);
   endtask

   task automatic test_inhibit();
      do_reset();
      write_w(2'd3, 8'd80);          // cnt0
      write_w(2'd0, 8'd50);          // cnt1
      step(); step();                // cnt2, cnt3
      spike_in = 4'b0001;            // cnt0
      step();
      n_checks++; if (synaptic_current !== 8'd50) begin n_fail++; $display("FAIL inh_load: got %0d expected 50", synaptic_current); end
      spike_in = 4'b1000;            // cnt1
      step();
      idle();
`ifdef SYN_INHIBIT_EN
      n_checks++; if (synaptic_current !== 8'd0) begin n_fail++; $display("FAIL inh_cur: got %0d expected 0", synaptic_current); end
      n_checks++; if (sat_flag !== 1'b1) begin n_fail++; $display("FAIL inh_sat: got %b expected 1", sat_flag); end
`else
      n_checks++; if (synaptic_current !== 8'd130) begin n_fail++; $display("FAIL inh_cur: got %0d expected 130", synaptic_current); end
      n_checks++; if (sat_flag !== 1'b0) begin n_fail++; $display("FAIL inh_sat: got %b expected 0", sat_flag); end
`endif
      $display("test_inhibit done: cur=%0d sat=%b", synaptic_current, sat_flag);
   endtask

   task automatic test_mid_reset();
      do_reset();
      write_w(2'd0, 8'd100);         // cnt0
      spike_in = 4'b0001;            // cnt1
      step();
      idle();
      step();                        // cnt2
      n_checks++; if (synaptic_current !== 8'd100) begin n_fail++; $display("FAIL mr_load: got %0d expected 100", synaptic_current); end
      rst_n = 1'b1; spike_in = 4'b0001; wr_en = 1'b1; wr_addr = 2'd1; wr_data = 8'd5; sat_clr = 1'b1;
      step();                        // would be cnt3 tick
      rst_n = 1'b0;
      idle();
      n_checks++; if (synaptic_current !== 8'd0) begin n_fail++; $display("FAIL mr_cur: got %0d expected 0", synaptic_current); end
      n_checks++; if (active !== 1'b0) begin n_fail++; $display("FAIL mr_active: got %b expected 0", active); end
      spike_in = 4'b0011;            // cnt0: weights cleared, write overridden
      step();
      idle();
      n_checks++; if (synaptic_current !== 8'd0) begin n_fail++; $display("FAIL mr_w_cleared: got %0d expected 0", synaptic_current); end
      write_w(2'd0, 8'd40);          // cnt1
      spike_in = 4'b0001;            // cnt2: no tick if counter restarted
      step();
      idle();
      n_checks++; if (synaptic_current !== 8'd40) begin n_fail++; $display("FAIL mr_cnt_notick: got %0d expected 40", synaptic_current); end
      step();                        // cnt3 tick
      n_checks++; if (synaptic_current !== 8'd30) begin n_fail++; $display("FAIL mr_cnt_tick: got %0d expected 30", synaptic_current); end
      $display("test_mid_reset done: cur=%0d", synaptic_current);
   endtask

   initial begin
      rst_n = 1'b1;
      idle();
      step();
      test_reset();
      test_decay();
      test_write_latency();
      test_saturation();
      test_decay_to_zero();
      test_inhibit();
      test_mid_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
